// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: recovers the hex value shown on each digit of a multiplexed 7-segment scan bus.
// Optional macro SEG7_CAP_BLANK_EN: an all-off pattern on a driven digit is captured as a blank (adds blank_mask).

module seg7_scan_capture #(
   parameter int N_DIGITS       = 4,
   parameter int STABLE_CYCLES  = 4,
   parameter int SEG_ACTIVE_LOW = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              seg,
   input  logic [N_DIGITS-1:0]     an,
   output logic [4*N_DIGITS-1:0]   digits,
   output logic [N_DIGITS-1:0]     dig_valid,
   output logic                    cap_stb,
   output logic [2:0]              cap_idx,
   output logic                    frame_stb,
   output logic                    err_seg,
   output logic                    err_anode
`ifdef SEG7_CAP_BLANK_EN
   ,
   output logic [N_DIGITS-1:0]     blank_mask
`endif
);

   typedef enum logic [0:0] {
      ST_WAIT = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   localparam logic [15:0]         STABLE_L = 16'(STABLE_CYCLES);
   localparam logic [N_DIGITS-1:0] ALL_SEEN = {N_DIGITS{1'b1}};
   localparam logic [N_DIGITS-1:0] NO_BITS  = {N_DIGITS{1'b0}};

   // Returns {hit, value}; hit is 0 for any pattern outside the hex font.
   function automatic logic [4:0] decode_seg(input logic [6:0] s);
      logic [4:0] r;
      case (s)
         7'h7E:   r = {1'b1, 4'h0};
         7'h30:   r = {1'b1, 4'h1};
         7'h6D:   r = {1'b1, 4'h2};
         7'h79:   r = {1'b1, 4'h3};
         7'h33:   r = {1'b1, 4'h4};
         7'h5B:   r = {1'b1, 4'h5};
         7'h5F:   r = {1'b1, 4'h6};
         7'h70:   r = {1'b1, 4'h7};
         7'h7F:   r = {1'b1, 4'h8};
         7'h7B:   r = {1'b1, 4'h9};
         7'h77:   r = {1'b1, 4'hA};
         7'h1F:   r = {1'b1, 4'hB};
         7'h4E:   r = {1'b1, 4'hC};
         7'h3D:   r = {1'b1, 4'hD};
         7'h4F:   r = {1'b1, 4'hE};
         7'h47:   r = {1'b1, 4'hF};
         default: r = {1'b0, 4'h0};
      endcase
      return r;
   endfunction

   function automatic logic [3:0] bit_count(input logic [N_DIGITS-1:0] v);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < N_DIGITS; i++) begin
         c = c + {3'd0, v[i]};
      end
      return c;
   endfunction

   function automatic logic [2:0] onehot_index(input logic [N_DIGITS-1:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < N_DIGITS; i++) begin
         idx = v[i] ? i[2:0] : idx;
      end
      return idx;
   endfunction

   logic [6:0]            seg_in_s;
   logic [N_DIGITS-1:0]   an_in_s;
   logic [6:0]            s_seg_q, p_seg_q;
   logic [N_DIGITS-1:0]   s_an_q, p_an_q;
   logic [15:0]           cnt_q, cnt_d;
   state_t                state_q, state_d;
   logic                  diff_s, eval_s;

   logic [4*N_DIGITS-1:0] digits_q, digits_d;
   logic [N_DIGITS-1:0]   dig_valid_q, dig_valid_d;
   logic [N_DIGITS-1:0]   seen_q, seen_d;
   logic                  cap_stb_q, cap_stb_d;
   logic [2:0]            cap_idx_q, cap_idx_d;
   logic                  frame_stb_q, frame_stb_d;
   logic                  err_seg_q, err_seg_d;
   logic                  err_anode_q, err_anode_d;
`ifdef SEG7_CAP_BLANK_EN
   logic [N_DIGITS-1:0]   blank_mask_q, blank_mask_d;
`endif

   logic [4:0]            dec_s;
   logic [3:0]            n_on_s;
   logic [2:0]            idx_s;
   logic [N_DIGITS-1:0]   seen_set_s;
   logic                  frame_hit_s;
   logic [N_DIGITS-1:0]   seen_after_s;

   // Polarity is normalised before the first flop so all internal logic is active-high.
   assign seg_in_s     = (SEG_ACTIVE_LOW != 0) ? ~seg : seg;
   assign an_in_s      = (SEG_ACTIVE_LOW != 0) ? ~an  : an;
   assign diff_s       = (s_seg_q != p_seg_q) || (s_an_q != p_an_q);
   assign dec_s        = decode_seg(s_seg_q);
   assign n_on_s       = bit_count(s_an_q);
   assign idx_s        = onehot_index(s_an_q);
   assign seen_set_s   = seen_q | s_an_q;
   assign frame_hit_s  = (seen_set_s == ALL_SEEN);
   assign seen_after_s = frame_hit_s ? NO_BITS : seen_set_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_seg_q <= 7'h00;
         p_seg_q <= 7'h00;
         s_an_q  <= NO_BITS;
         p_an_q  <= NO_BITS;
         cnt_q   <= 16'd0;
      end else begin
         s_seg_q <= seg_in_s;
         p_seg_q <= s_seg_q;
         s_an_q  <= an_in_s;
         p_an_q  <= s_an_q;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_WAIT;
      end else begin
         state_q <= state_d;
      end
   end

   // A run is evaluated once, on the edge its length reaches STABLE_CYCLES.
   always_comb begin
      cnt_d   = cnt_q;
      state_d = state_q;
      eval_s  = 1'b0;
      if (diff_s) begin
         cnt_d = 16'd1;
      end else if (cnt_q != STABLE_L) begin
         cnt_d = cnt_q + 16'd1;
      end else begin
         cnt_d = cnt_q;
      end
      if ((diff_s || (state_q == ST_WAIT)) && (cnt_d == STABLE_L)) begin
         eval_s  = 1'b1;
         state_d = ST_HOLD;
      end else if (diff_s) begin
         state_d = ST_WAIT;
      end else begin
         state_d = state_q;
      end
   end

   always_comb begin
      digits_d    = digits_q;
      dig_valid_d = dig_valid_q;
      seen_d      = seen_q;
      cap_stb_d   = 1'b0;
      cap_idx_d   = cap_idx_q;
      frame_stb_d = 1'b0;
      err_seg_d   = 1'b0;
      err_anode_d = 1'b0;
`ifdef SEG7_CAP_BLANK_EN
      blank_mask_d = blank_mask_q;
`endif
      if (eval_s) begin
         if (n_on_s > 4'd1) begin
            err_anode_d = 1'b1;
         end else if (n_on_s == 4'd1) begin
            if (dec_s[4]) begin
               for (int i = 0; i < N_DIGITS; i++) begin
                  digits_d[4*i +: 4] = s_an_q[i] ? dec_s[3:0] : digits_q[4*i +: 4];
               end
               dig_valid_d = dig_valid_q | s_an_q;
               seen_d      = seen_after_s;
               cap_stb_d   = 1'b1;
               cap_idx_d   = idx_s;
               frame_stb_d = frame_hit_s;
`ifdef SEG7_CAP_BLANK_EN
               blank_mask_d = blank_mask_q & ~s_an_q;
            end else if (s_seg_q == 7'h00) begin
               dig_valid_d  = dig_valid_q | s_an_q;
               seen_d       = seen_after_s;
               cap_stb_d    = 1'b1;
               cap_idx_d    = idx_s;
               frame_stb_d  = frame_hit_s;
               blank_mask_d = blank_mask_q | s_an_q;
`endif
            end else begin
               err_seg_d = 1'b1;
            end
         end else begin
            seen_d = seen_q;
         end
      end else begin
         seen_d = seen_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits_q    <= {(4*N_DIGITS){1'b0}};
         dig_valid_q <= NO_BITS;
         seen_q      <= NO_BITS;
         cap_stb_q   <= 1'b0;
         cap_idx_q   <= 3'd0;
         frame_stb_q <= 1'b0;
         err_seg_q   <= 1'b0;
         err_anode_q <= 1'b0;
`ifdef SEG7_CAP_BLANK_EN
         blank_mask_q <= NO_BITS;
`endif
      end else begin
         digits_q    <= digits_d;
         dig_valid_q <= dig_valid_d;
         seen_q      <= seen_d;
         cap_stb_q   <= cap_stb_d;
         cap_idx_q   <= cap_idx_d;
         frame_stb_q <= frame_stb_d;
         err_seg_q   <= err_seg_d;
         err_anode_q <= err_anode_d;
`ifdef SEG7_CAP_BLANK_EN
         blank_mask_q <= blank_mask_d;
`endif
      end
   end

   assign digits    = digits_q;
   assign dig_valid = dig_valid_q;
   assign cap_stb   = cap_stb_q;
   assign cap_idx   = cap_idx_q;
   assign frame_stb = frame_stb_q;
   assign err_seg   = err_seg_q;
   assign err_anode = err_anode_q;
`ifdef SEG7_CAP_BLANK_EN
   assign blank_mask = blank_mask_q;
`endif

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive end of a multiplexed 7-segment display bus: samples segment lines plus one-hot digit enables and recovers the hex value shown on each digit.
- Sits between a scanned display driver (or board-level display port) and the checker/logic that needs the displayed values.
- Filters scan transitions with a stability window, decodes segment patterns back to 4-bit values, and flags illegal patterns.

Parameters:
- N_DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before capture (1..65535).
- SEG_ACTIVE_LOW, 0, 1 = seg and an inputs are active-low; inverted at the input register.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seg  in  7  segment lines {a,b,c,d,e,f,g}, seg[6]=a, seg[0]=g.
- an  in  N_DIGITS  digit enables, one-hot when a digit is driven.
- digits  out  4*N_DIGITS  recovered values, digit i at [4i+3:4i].
- dig_valid  out  N_DIGITS  digit i has been captured since reset.
- cap_stb  out  1  one-cycle pulse per capture.
- cap_idx  out  3  index of digit captured (valid with cap_stb).
- frame_stb  out  1  one-cycle pulse when every digit has been captured since the previous frame_stb.
- err_seg  out  1  one-cycle pulse: stable pattern not in decode table.
- err_anode  out  1  one-cycle pulse: stable an has more than one bit set.

Behaviour:
- Reset: all outputs 0, input registers 0, run counter 0, seen mask 0, state WAIT. Reset mid-run aborts the pending capture; no pulse is emitted.
- Input stage: seg/an registered once (inverted if SEG_ACTIVE_LOW). Sample S and previous sample P held internally.
- Run counter: S != P -> counter = 1, state WAIT. S == P -> counter increments, saturating at STABLE_CYCLES.
- States: WAIT (counting), HOLD (run already evaluated; wait for S != P). One evaluation per run.
- Evaluation happens in WAIT on the edge the run length reaches STABLE_CYCLES. Latency: inputs changed and held from edge k are evaluated at edge k+STABLE_CYCLES; outputs visible after that edge. Go to HOLD.
- At evaluation:
  - an == 0: blank period; no pulse; HOLD.
  - an with more than one bit set: err_anode = 1; digits unchanged.
  - an one-hot, seg in table: digits[i], dig_valid[i] and seen[i] set; cap_stb = 1; cap_idx = i.
  - an one-hot, seg not in table: err_seg = 1; digit unchanged; seen unchanged.
- Decode table (seg hex -> value): 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9, 77->A, 1F->b, 4E->C, 3D->d, 4F->E, 47->F.
- Frame tracking:
  - When a capture makes seen all-ones, frame_stb pulses in the same cycle as cap_stb and seen clears to 0.
  - Recapturing an already-seen digit updates digits only.
- Pulses last exactly one cycle. cap_stb, err_seg and err_anode are mutually exclusive.
- Pattern change during HOLD restarts counting, even if the same digit returns later.

Optional Feature:
- SEG7_CAP_BLANK_EN defined:
  - seg == 00 with an one-hot is a legal blank digit. Digit i is marked seen and captured with cap_stb.
  - digits[i] is unchanged.
  - Added output blank_mask (N_DIGITS) has bit i set; any valid table capture clears it.
- SEG7_CAP_BLANK_EN undefined: blank_mask port is absent, and seg == 00 with an one-hot gives err_seg.

Test Plan:
- N_DIGITS=4, STABLE_CYCLES=4: an=0001, seg=30 from edge 0 -> cap_stb=1, cap_idx=0 and digits[3:0]=1 after edge 4. Only one pulse while held 20 cycles.
- Scan an=0001/0010/0100/1000 with seg 6D/79/33/5B, 6 cycles each -> four cap_stb pulses, digits=16'h5432. frame_stb coincides with the fourth cap_stb; seen is 0 after it.
- Glitch: seg toggles every 2 cycles with STABLE_CYCLES=4 -> no cap_stb and no error for 40 cycles.
- an=0011, seg=7E held 6 cycles -> one err_anode pulse at edge 4, digits unchanged. seg=01 (g only) with an=0100 -> one err_seg pulse.
- Assert rst_n low at edge 2 of a pending capture, release, then hold an=0010, seg=47 -> all outputs 0 during reset. Capture gives digits[7:4]=F after STABLE_CYCLES.
- SEG_ACTIVE_LOW=1: an=1110, seg=~7F (00) -> digit 0 = 8. With SEG7_CAP_BLANK_EN, seg input 7F (blank) -> blank_mask[0]=1.
